swap_stream_checker: RTL and testbench

//   Receive-side checker for the two-wire register-swap stream (a, b) driven by
//   the non-blocking swap block. On every enabled clock it confirms that the
//   new pair is the previous pair exchanged (a_new == b_old, b_new == a_old).
//   It acquires lock, tracks lock, and counts matches and errors. It sits in the

---
 rtl/swap_stream_checker.sv | 153 +++++++++++++++
 tb/tb_swap_stream_checker.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/swap_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : swap_stream_checker
// Purpose  : Receive-side checker for a two-wire register-swap stream (a, b).
//            Confirms each enabled sample is the previous pair exchanged,
//            acquires and tracks lock, and keeps saturating match/error counts.
// Revision : 1.0 - initial release
// ============================================================================
module swap_stream_checker #(
    parameter int CNT_W     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic [1:0]       state,
    output logic             locked,
    output logic             err_pulse,
    output logic             degenerate,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(ERR_LIMIT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACQ    = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [RUN_W-1:0]  c_RUN_LIM  = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] c_MISS_LIM = MISS_W'(ERR_LIMIT);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};

    // Previous sample and whether it is meaningful yet
    logic              r_a_q;
    logic              r_b_q;
    logic              r_hist_valid;
    // Consecutive-match run (ACQ) and consecutive-miss run (LOCKED)
    logic [RUN_W-1:0]  r_run;
    logic [MISS_W-1:0] r_miss;

    logic              w_match;
    logic              w_degen;
    logic [RUN_W-1:0]  w_run_inc;
    logic [MISS_W-1:0] w_miss_inc;
    logic [CNT_W-1:0]  w_match_sat;
    logic [CNT_W-1:0]  w_err_sat;

    // Swap comparison against history and saturating counter increments
    always_comb begin
        w_match     = (a == r_b_q) && (b == r_a_q);
        // With a==b and a_q==b_q an exchange cannot be told from a hold
        w_degen     = (a == b) && (r_a_q == r_b_q);
        w_run_inc   = r_run + RUN_W'(1);
        w_miss_inc  = r_miss + MISS_W'(1);
        w_match_sat = (match_cnt == c_CNT_MAX) ? match_cnt : match_cnt + CNT_W'(1);
        w_err_sat   = (err_cnt == c_CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
    end

    // Lock FSM, history capture and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= c_IDLE;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            degenerate   <= 1'b0;
            match_cnt    <= '0;
            err_cnt      <= '0;
            r_a_q        <= 1'b0;
            r_b_q        <= 1'b0;
            r_hist_valid <= 1'b0;
            r_run        <= '0;
            r_miss       <= '0;
        end else if (clr) begin
            state        <= c_IDLE;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            degenerate   <= 1'b0;
            match_cnt    <= '0;
            err_cnt      <= '0;
            r_a_q        <= 1'b0;
            r_b_q        <= 1'b0;
            r_hist_valid <= 1'b0;
            r_run        <= '0;
            r_miss       <= '0;
        end else if (en) begin
            r_a_q        <= a;
            r_b_q        <= b;
            r_hist_valid <= 1'b1;
            err_pulse    <= 1'b0;
            if (!r_hist_valid) begin
                // First sample only primes the history
                state  <= c_ACQ;
                locked <= 1'b0;
                r_run  <= '0;
                r_miss <= '0;
            end else if (w_degen) begin
                degenerate <= 1'b1;
            end else begin
                degenerate <= 1'b0;
                case (state)
                    c_ACQ: begin
                        if (w_match) begin
                            match_cnt <= w_match_sat;
                            if (w_run_inc == c_RUN_LIM) begin
                                state  <= c_LOCKED;
                                locked <= 1'b1;
                                r_run  <= '0;
                                r_miss <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    c_LOCKED: begin
                        if (w_match) begin
                            match_cnt <= w_match_sat;
                            r_miss    <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            err_cnt   <= w_err_sat;
                            if (w_miss_inc == c_MISS_LIM) begin
                                state  <= c_ACQ;
                                locked <= 1'b0;
                                r_run  <= '0;
                                r_miss <= '0;
                            end else begin
                                r_miss <= w_miss_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= c_ACQ;
                        locked <= 1'b0;
                        r_run  <= '0;
                        r_miss <= '0;
                    end
                endcase
            end
        end else begin
            err_pulse <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_swap_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_swap_stream_checker
// Purpose  : Scoreboard bench for swap_stream_checker. Directed vectors push
//            hand-computed expectations; a monitor pops and compares one per
//            clock. A second instance with CNT_W=2 shares the stimulus to
//            exercise counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swap_stream_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       a;
    logic       b;

    logic [1:0] state,  state2;
    logic       locked, locked2;
    logic       err_pulse, err_pulse2;
    logic       degenerate, degenerate2;
    logic [7:0] match_cnt, err_cnt;
    logic [1:0] match_cnt2, err_cnt2;

    typedef struct {
        logic [1:0] st;
        logic       ep;
        logic       dg;
        int         mc;
        int         ec;
        int         id;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    swap_stream_checker #(.CNT_W(8), .LOCK_CNT(4), .ERR_LIMIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .state(state), .locked(locked), .err_pulse(err_pulse),
        .degenerate(degenerate), .match_cnt(match_cnt), .err_cnt(err_cnt)
    );

    swap_stream_checker #(.CNT_W(2), .LOCK_CNT(4), .ERR_LIMIT(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .state(state2), .locked(locked2), .err_pulse(err_pulse2),
        .degenerate(degenerate2), .match_cnt(match_cnt2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int id, int act, int exp);
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endfunction

    function automatic int sat3(int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Compare both instances against one expectation
    function automatic void check_all(exp_t e);
        n_vec++;
        chk("state",       e.id, int'(state),      int'(e.st));
        chk("locked",      e.id, int'(locked),     (e.st == 2'd2) ? 1 : 0);
        chk("err_pulse",   e.id, int'(err_pulse),  int'(e.ep));
        chk("degenerate",  e.id, int'(degenerate), int'(e.dg));
        chk("match_cnt",   e.id, int'(match_cnt),  e.mc);
        chk("err_cnt",     e.id, int'(err_cnt),    e.ec);
        chk("state_s",     e.id, int'(state2),     int'(e.st));
        chk("locked_s",    e.id, int'(locked2),    (e.st == 2'd2) ? 1 : 0);
        chk("err_pulse_s", e.id, int'(err_pulse2), int'(e.ep));
        chk("degen_s",     e.id, int'(degenerate2), int'(e.dg));
        chk("match_sat",   e.id, int'(match_cnt2), sat3(e.mc));
        chk("err_sat",     e.id, int'(err_cnt2),   sat3(e.ec));
    endfunction

    task automatic step(input logic e, input logic c, input logic ia, input logic ib,
                        input logic [1:0] st, input logic ep, input logic dg,
                        input int mc, input int ec);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; a = ia; b = ib;
        x.st = st; x.ep = ep; x.dg = dg; x.mc = mc; x.ec = ec; x.id = vec_id;
        vec_id++;
        q.push_back(x);
    endtask

    // Monitor: one expectation per clock, sampled after the edge settles
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check_all(x);
            end
        end
    end

    initial begin
        exp_t z;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 2'd0, 0, 0, 0, 0);

        // Acquire
        step(1, 0, 1, 0, 2'd1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2'd1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 2'd1, 0, 0, 2, 0);
        step(1, 0, 0, 1, 2'd1, 0, 0, 3, 0);
        step(1, 0, 1, 0, 2'd2, 0, 0, 4, 0);
        // Single glitch keeps lock
        step(1, 0, 1, 0, 2'd2, 1, 0, 4, 1);
        step(1, 0, 0, 1, 2'd2, 0, 0, 5, 1);
        step(1, 0, 1, 0, 2'd2, 0, 0, 6, 1);
        // Two consecutive mismatches drop lock
        step(1, 0, 1, 0, 2'd2, 1, 0, 6, 2);
        step(1, 0, 1, 0, 2'd1, 1, 0, 6, 3);
        // Degenerate stream, then enable freeze
        step(1, 0, 1, 1, 2'd1, 0, 0, 6, 3);
        step(1, 0, 1, 1, 2'd1, 0, 1, 6, 3);
        step(1, 0, 1, 1, 2'd1, 0, 1, 6, 3);
        step(1, 0, 1, 1, 2'd1, 0, 1, 6, 3);
        step(0, 0, 0, 1, 2'd1, 0, 1, 6, 3);
        step(0, 0, 1, 0, 2'd1, 0, 1, 6, 3);
        step(1, 0, 0, 1, 2'd1, 0, 0, 6, 3);
        // Clear wins over enable
        step(1, 1, 1, 0, 2'd0, 0, 0, 0, 0);
        // Re-lock and run six matches (narrow instance saturates at 3)
        step(1, 0, 1, 0, 2'd1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2'd1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 2'd1, 0, 0, 2, 0);
        step(1, 0, 0, 1, 2'd1, 0, 0, 3, 0);
        step(1, 0, 1, 0, 2'd2, 0, 0, 4, 0);
        step(1, 0, 0, 1, 2'd2, 0, 0, 5, 0);
        step(1, 0, 1, 0, 2'd2, 0, 0, 6, 0);
        // Pulse, then en low forces it off without moving history
        step(1, 0, 1, 0, 2'd2, 1, 0, 6, 1);
        step(0, 0, 0, 1, 2'd2, 0, 0, 6, 1);
        step(1, 0, 0, 1, 2'd2, 0, 0, 7, 1);

        // Asynchronous reset mid-cycle while locked
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        z.st = 2'd0; z.ep = 1'b0; z.dg = 1'b0; z.mc = 0; z.ec = 0; z.id = 999;
        check_all(z);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 0, 2'd0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2'd0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 2'd1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 2'd1, 0, 0, 1, 0);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
